// File: rtl/spi_mem_ctrl.sv
// SPI-slave (mode 0, MSB first) bridge to a synchronous-read memory: address/RW header,
// then single-frame or auto-incrementing burst reads and writes. All SCLK activity arrives as clk-domain strobes.
module spi_mem_ctrl #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8,
   parameter int BURST  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs,
   input  logic              mosi,
   input  logic              sclk_pos,
   input  logic              sclk_neg,
   output logic              miso,
   output logic              miso_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]  HDR_LAST = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0]  DAT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic [2:0] {
      IDLE, HDR, RD_FETCH, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT, DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  bitcnt;
   logic [ADDR_W-1:0] hdr_sr;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         bitcnt    <= '0;
         hdr_sr    <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         miso      <= 1'b0;
         miso_oe   <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else begin
         mem_we <= 1'b0;
         // Deselect wins over any coincident strobe; a write strobe already out is not recalled.
         if (cs) begin
            state   <= IDLE;
            bitcnt  <= '0;
            hdr_sr  <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            miso_oe <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state  <= HDR;
                  bitcnt <= '0;
               end
               HDR: begin
                  if (sclk_pos) begin
                     if (bitcnt == HDR_LAST) begin
                        mem_addr <= hdr_sr;
                        bitcnt   <= '0;
                        state    <= mosi ? RD_FETCH : WR_SHIFT;
                     end else begin
                        hdr_sr <= {hdr_sr[ADDR_W-2:0], mosi};
                        bitcnt <= bitcnt + CNT_ONE;
                     end
                  end
               end
               RD_FETCH: state <= RD_LOAD;
               RD_LOAD: begin
                  tx_sr   <= mem_rdata;
                  miso_oe <= 1'b1;
                  state   <= RD_SHIFT;
               end
               RD_SHIFT: begin
                  if (sclk_neg) begin
                     miso  <= tx_sr[DATA_W-1];
                     tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                  end
                  if (sclk_pos) begin
                     if (bitcnt == DAT_LAST) begin
                        bitcnt <= '0;
                        if (BURST != 0) begin
                           mem_addr <= mem_addr + ADDR_ONE;
                           state    <= RD_FETCH;
                        end else begin
                           miso_oe <= 1'b0;
                           state   <= DONE;
                        end
                     end else begin
                        bitcnt <= bitcnt + CNT_ONE;
                     end
                  end
               end
               WR_SHIFT: begin
                  if (sclk_pos) begin
                     rx_sr <= {rx_sr[DATA_W-2:0], mosi};
                     if (bitcnt == DAT_LAST) begin
                        mem_wdata <= {rx_sr[DATA_W-2:0], mosi};
                        mem_we    <= 1'b1;
                        bitcnt    <= '0;
                        state     <= WR_COMMIT;
                     end else begin
                        bitcnt <= bitcnt + CNT_ONE;
                     end
                  end
               end
               WR_COMMIT: begin
                  if (BURST != 0) begin
                     mem_addr <= mem_addr + ADDR_ONE;
                     state    <= WR_SHIFT;
                  end else begin
                     state <= DONE;
                  end
               end
               DONE: miso_oe <= 1'b0;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench: one single-frame and one burst controller share the SPI stimulus,
// each backed by its own synchronous-read memory model with a write log.
module tb_spi_mem_ctrl;

   logic clk, rst_n, cs, mosi, sclk_pos, sclk_neg;

   logic       miso_s, oe_s, we_s, busy_s;
   logic [6:0] addr_s;
   logic [7:0] wdata_s, rdata_s;
   logic       miso_b, oe_b, we_b, busy_b;
   logic [6:0] addr_b;
   logic [7:0] wdata_b, rdata_b;

   logic [7:0] mem_s [0:127];
   logic [7:0] mem_b [0:127];
   logic [6:0] wa_s[$], wa_b[$];
   logic [7:0] wd_s[$], wd_b[$];

   int n_chk  = 0;
   int n_pass = 0;

   spi_mem_ctrl #(.ADDR_W(7), .DATA_W(8), .BURST(0)) u_single (
      .clk(clk), .rst_n(rst_n), .cs(cs), .mosi(mosi),
      .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
      .miso(miso_s), .miso_oe(oe_s), .mem_addr(addr_s), .mem_we(we_s),
      .mem_wdata(wdata_s), .mem_rdata(rdata_s), .busy(busy_s));

   spi_mem_ctrl #(.ADDR_W(7), .DATA_W(8), .BURST(1)) u_burst (
      .clk(clk), .rst_n(rst_n), .cs(cs), .mosi(mosi),
      .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
      .miso(miso_b), .miso_oe(oe_b), .mem_addr(addr_b), .mem_we(we_b),
      .mem_wdata(wdata_b), .mem_rdata(rdata_b), .busy(busy_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      rdata_s <= mem_s[addr_s];
      rdata_b <= mem_b[addr_b];
      if (we_s) begin
         mem_s[addr_s] <= wdata_s;
         wa_s.push_back(addr_s);
         wd_s.push_back(wdata_s);
      end
      if (we_b) begin
         mem_b[addr_b] <= wdata_b;
         wa_b.push_back(addr_b);
         wd_b.push_back(wdata_b);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One SCLK period (half period 5 clk): miso sampled just before the rising strobe.
   task automatic spi_bit(input logic b, output logic r0, output logic r1);
      mosi = b;
      repeat (4) @(posedge clk);
      #1;
      r0 = miso_s;
      r1 = miso_b;
      sclk_pos = 1'b1;
      @(posedge clk); #1 sclk_pos = 1'b0;
      repeat (4) @(posedge clk);
      #1 sclk_neg = 1'b1;
      @(posedge clk); #1 sclk_neg = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] v, output logic [7:0] r0, output logic [7:0] r1);
      logic a, b;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(v[i], a, b);
         r0[i] = a;
         r1[i] = b;
      end
   endtask

   task automatic cs_low();
      @(posedge clk); #1 cs = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic cs_high();
      repeat (4) @(posedge clk);
      #1 cs = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      wa_s.delete(); wd_s.delete(); wa_b.delete(); wd_b.delete();
   endtask

   logic [7:0] r0, r1;
   logic       a, b;

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem_s[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
      mem_b[16] = 8'h01; mem_b[17] = 8'h02; mem_b[18] = 8'h03;
      rst_n = 1'b0; cs = 1'b1; mosi = 1'b0; sclk_pos = 1'b0; sclk_neg = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_single", {miso_s, oe_s, we_s, busy_s, addr_s, wdata_s}, 0);
      check("reset_burst",  {miso_b, oe_b, we_b, busy_b, addr_b, wdata_b}, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single write 0x15 <- 0xA5, then extra SCLK traffic that must not write.
      clear_logs();
      cs_low();
      check("busy_after_cs_fall", busy_s, 1);
      spi_byte(8'h2A, r0, r1);
      spi_byte(8'hA5, r0, r1);
      spi_byte(8'h3C, r0, r1);
      cs_high();
      check("single_wr_count", wa_s.size(), 1);
      check("single_wr_addr", wa_s[0], 7'h15);
      check("single_wr_data", wd_s[0], 8'hA5);
      check("busy_after_cs_rise", busy_s, 0);

      // Single read of 0x15.
      clear_logs();
      cs_low();
      spi_byte(8'h2B, r0, r1);
      check("rd_oe_shift", oe_s, 1);
      spi_byte(8'h00, r0, r1);
      check("rd_data_single", r0, 8'hA5);
      check("rd_data_burst_dut", r1, 8'hA5);
      check("rd_oe_done", oe_s, 0);
      check("rd_oe_burst_prefetch", oe_b, 1);
      cs_high();
      check("rd_oe_after_cs", {oe_s, oe_b}, 0);
      check("rd_no_writes", wa_s.size() + wa_b.size(), 0);

      // Burst write crossing the top of the address space.
      clear_logs();
      cs_low();
      spi_byte(8'hFE, r0, r1);
      spi_byte(8'h11, r0, r1);
      spi_byte(8'h22, r0, r1);
      cs_high();
      check("wrap_count", wa_b.size(), 2);
      check("wrap_addr0", wa_b[0], 7'h7F);
      check("wrap_data0", wd_b[0], 8'h11);
      check("wrap_addr1", wa_b[1], 7'h00);
      check("wrap_data1", wd_b[1], 8'h22);

      // Burst read 0x10..0x12.
      cs_low();
      spi_byte(8'h21, r0, r1);
      spi_byte(8'h00, r0, r1);
      check("burst_rd0", r1, 8'h01);
      spi_byte(8'h00, r0, r1);
      check("burst_rd1", r1, 8'h02);
      spi_byte(8'h00, r0, r1);
      check("burst_rd2", r1, 8'h03);
      cs_high();

      // Abort after 5 data bits, then a clean write must decode from bit 0.
      clear_logs();
      cs_low();
      spi_byte(8'h40, r0, r1);
      spi_bit(1'b1, a, b); spi_bit(1'b0, a, b); spi_bit(1'b1, a, b);
      spi_bit(1'b1, a, b); spi_bit(1'b0, a, b);
      cs_high();
      check("abort_no_wr_single", wa_s.size(), 0);
      check("abort_no_wr_burst", wa_b.size(), 0);
      cs_low();
      spi_byte(8'h66, r0, r1);
      spi_byte(8'h5A, r0, r1);
      cs_high();
      check("post_abort_count", wa_s.size(), 1);
      check("post_abort_addr", wa_s[0], 7'h33);
      check("post_abort_data", wd_s[0], 8'h5A);
      check("post_abort_burst_addr", wa_b[0], 7'h33);

      // Reset in the middle of a burst write.
      cs_low();
      spi_byte(8'h80, r0, r1);
      spi_byte(8'h77, r0, r1);
      spi_bit(1'b1, a, b); spi_bit(1'b1, a, b); spi_bit(1'b0, a, b);
      clear_logs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midreset_burst", {miso_b, oe_b, we_b, busy_b, addr_b, wdata_b}, 0);
      check("midreset_single_busy", busy_s, 0);
      rst_n = 1'b1;
      cs_high();
      check("midreset_no_writes", wa_s.size() + wa_b.size(), 0);
      cs_low();
      spi_byte(8'h67, r0, r1);
      spi_byte(8'h00, r0, r1);
      cs_high();
      check("post_reset_rd_single", r0, 8'h5A);
      check("post_reset_rd_burst", r1, 8'h5A);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

Parametrised SPI-slave memory controller. It sits between the three input conditioners (MOSI, SCLK, CS) and the data memory. It decodes an address/RW header, then performs single-word or auto-incrementing burst reads and writes against a synchronous-read memory. Everything runs on the FPGA `clk`; SPI edges arrive as one-`clk` strobes from the conditioners, so no logic is clocked by SCLK.

## Interface
Parameters:
- `ADDR_W`, 7: address bits in header and on `mem_addr`.
- `DATA_W`, 8: bits per data frame and memory word width.
- `BURST`, 1: 1 = auto-increment address and continue after each frame; 0 = one frame per CS assertion.

Ports:
- `clk` in 1: FPGA clock; sole clock of the block.
- `rst_n` in 1: synchronous, active-low reset.
- `cs` in 1: conditioned chip select, active-low.
- `mosi` in 1: conditioned MOSI level.
- `sclk_pos` in 1: one-`clk` strobe on SCLK rising edge.
- `sclk_neg` in 1: one-`clk` strobe on SCLK falling edge.
- `miso` out 1: serial read data (registered).
- `miso_oe` out 1: MISO tristate enable; drives the pin buffer.
- `mem_addr` out ADDR_W: memory address (registered).
- `mem_we` out 1: one-`clk` write strobe.
- `mem_wdata` out DATA_W: write data.
- `mem_rdata` in DATA_W: memory read data, valid 1 `clk` after `mem_addr` changes.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- SPI mode 0, MSB first. Master changes MOSI on falling edges; slave samples on `sclk_pos`, drives `miso` on `sclk_neg`.
- Header: ADDR_W+1 bits. The first ADDR_W bits are the address, MSB first. The last bit is R/W: 1 = read, 0 = write.
- States and transitions:
  - IDLE → HDR when `cs`=0.
  - HDR: shift `mosi` on each `sclk_pos`; `bitcnt` counts 0..ADDR_W. When the last header bit is sampled, latch `mem_addr`. Then go to RD_FETCH if R/W=1, else WR_SHIFT.
  - RD_FETCH: one `clk` wait for memory latency → RD_LOAD.
  - RD_LOAD: `tx_sr <= mem_rdata`, `miso_oe <= 1`, then → RD_SHIFT.
  - RD_SHIFT: on `sclk_neg`, `miso <= tx_sr[DATA_W-1]` and `tx_sr <<= 1`. Count `sclk_pos` strobes. After DATA_W strobes: if BURST=1, `mem_addr <= mem_addr+1` and go to RD_FETCH; if BURST=0, go to DONE.
  - WR_SHIFT: shift `mosi` into `rx_sr` on `sclk_pos`. After DATA_W bits, go to WR_COMMIT.
  - WR_COMMIT: assert `mem_we`=1 for exactly one `clk`, with `mem_wdata=rx_sr`. If BURST=1, increment `mem_addr` on the following `clk` and return to WR_SHIFT; if BURST=0, go to DONE.
  - DONE: ignore all SCLK strobes; `miso_oe`=0.
- Address increment wraps modulo 2^ADDR_W: all-ones + 1 = 0.
- `cs`=1 in any state forces IDLE on the next `clk`. This has priority over every other event, including a coincident `sclk_pos`. Side effects:
  - `miso_oe` deasserts.
  - A partially shifted write word is discarded; `mem_we` never fires for it.
  - A WR_COMMIT already in progress completes its single `mem_we` cycle first.
- `sclk_pos`/`sclk_neg` strobes arriving in RD_FETCH/RD_LOAD are a protocol violation. They are ignored (no shift, no count).

## Timing
- Reset values (`rst_n`=0 at a `clk` edge):
  - state = IDLE
  - `miso`=0, `miso_oe`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0
  - counters and shift registers all 0.
  Reset mid-transaction aborts it identically.
- Read turnaround: last header `sclk_pos` → RD_FETCH (+1 `clk`) → RD_LOAD (+2) → `tx_sr` valid (+3). SCLK half-period must be ≥ 4 `clk` so `tx_sr` is loaded before the next `sclk_neg`. The same bound applies to burst prefetch.
- `miso` changes only on the `clk` after an `sclk_neg` strobe in RD_SHIFT.
- Write: `mem_we` rises 1 `clk` after the DATA_W-th data `sclk_pos`. Burst address increment lands 1 `clk` after `mem_we`.
- `busy` goes high 1 `clk` after `cs` falls and low 1 `clk` after `cs` rises.

## Test plan
- Reset: hold `rst_n`=0 for 3 `clk` mid-burst → all outputs 0, state IDLE, no `mem_we` pulse.
- Single write, BURST=0: header addr 0x15, RW=0, data 0xA5 → exactly one `mem_we` with `mem_addr`=0x15, `mem_wdata`=0xA5. Further SCLK activity before `cs`↑ causes no writes.
- Single read: memory[0x15]=0xA5; header 0x15, RW=1 → MISO returns bits 1,0,1,0,0,1,0,1 on successive falling edges; `miso_oe`=1 only during RD_SHIFT/DONE-free window, and 0 after `cs`↑.
- Burst write with wrap, ADDR_W=7: start 0x7F, data 0x11, 0x22 → writes 0x7F←0x11, then 0x00←0x22.
- Burst read: mem[0x10..0x12]=0x01,0x02,0x03; read 24 data bits → MISO stream 0x01 0x02 0x03.
- Abort: raise `cs` after 5 data bits of a write to 0x20 → no `mem_we`; next transaction decodes its header correctly from bit 0.
